// File: rtl/fetch_unit_if.sv
// Handshake bundles used by the instruction fetch stage.
//
//   imem_if  : word-read port towards instruction memory
//              req/addr driven by the requester, ack/rdata by the memory
//   instr_if : issue port towards the control unit
//              valid/instr/fields driven by the fetch stage,
//              ready/pc_src/branch_tgt driven by the control unit
//
// In both bundles the fetch stage takes the master modport.

interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

interface instr_if;
  logic        valid;
  logic        ready;
  logic        pc_src;
  logic [31:0] branch_tgt;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;

  modport master (
    output valid, instr, cond, op, funct, rn, rd,
    input  ready, pc_src, branch_tgt
  );
  modport slave (
    input  valid, instr, cond, op, funct, rn, rd,
    output ready, pc_src, branch_tgt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the control unit.
//
// Holds the PC, reads one instruction word at a time from instruction memory,
// latches it and presents the word plus its decoded fields to the control
// unit. When the control unit consumes the instruction the PC moves to PC+4,
// or to the (word-aligned) branch target if pc_src is set.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   imem      imem_if.master   memory read request (req/addr out, ack/rdata in)
//   iss       instr_if.master  issue handshake (valid/instr/fields out,
//                              ready/pc_src/branch_tgt in)
//   pc        out  address of the current instruction
//   pc_plus8  out  pc+8, the architectural PC read value
//   retired   out  count of consumed instructions (wraps)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  imem_if.master           imem,
  instr_if.master          iss,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus8,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] instr_q;
  logic        fetch_done;
  logic        consume;

  // An ack only counts while we are actually requesting; a stray or late ack
  // (for example one arriving just after reset) is dropped.
  assign fetch_done = (state == FETCH) && imem.ack;
  assign consume    = (state == ISSUE) && iss.ready;

  // NOTE: always_comb assigns every output a default first, so no path can
  //       leave state_d unassigned and infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = FETCH;
      FETCH:   if (fetch_done) state_d = ISSUE;
      ISSUE:   if (consume)    state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here uses non-blocking assignment so all updates
  //       see the pre-edge values of state, pc and retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      // NOTE: instr_q is an ordinary datapath register, not a memory; it is
      //       reset so the decoded fields are defined straight out of reset.
      instr_q <= '0;
      retired <= '0;
    end else begin
      state <= state_d;
      if (fetch_done) begin
        instr_q <= imem.rdata;
      end
      if (consume) begin
        // Low two bits of a branch target are discarded: fetch is always
        // word aligned and a misaligned target raises no exception.
        pc      <= iss.pc_src ? {iss.branch_tgt[31:2], 2'b00} : pc + 32'd4;
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // Request and address are pure functions of registered state, so both stay
  // stable for the whole FETCH phase and drop as soon as reset asserts.
  assign imem.req  = (state == FETCH);
  assign imem.addr = pc;

  assign iss.valid = (state == ISSUE);
  assign iss.instr = instr_q;

  // Fields are sliced from the latched word, never from imem.rdata, so they
  // stay stable while the control unit stalls.
  assign iss.cond  = instr_q[31:28];
  assign iss.op    = instr_q[27:26];
  assign iss.funct = instr_q[25:20];
  assign iss.rn    = instr_q[19:16];
  assign iss.rd    = instr_q[15:12];

  assign pc_plus8  = pc + 32'd8;

endmodule
